// File: rtl/uart_pkg.sv
// Definitions shared by the UART receiver and transmitter: FSM state
// encoding, default frame format and the baud divider helper.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

  localparam int UART_DATA_BITS = 8;
  localparam int UART_STOP_BITS = 1;

  function automatic int clks_per_bit(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Holding-register handshake between the UART receiver (master) and its
// consumer (slave), e.g. an MMIO data register.
interface uart_rx_if
  import uart_pkg::*;
#(
  parameter int DATA_BITS = UART_DATA_BITS
);
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 rx_ack;
  logic                 rx_overrun;
  logic                 rx_frame_err;
  logic                 rx_busy;

  modport master (
    output rx_data, rx_valid, rx_overrun, rx_frame_err, rx_busy,
    input  rx_ack
  );

  modport slave (
    input  rx_data, rx_valid, rx_overrun, rx_frame_err, rx_busy,
    output rx_ack
  );
endinterface

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the asynchronous rx pin plus a delayed copy for
// falling-edge detection. Flops reset to 1 so a reset looks like an idle line.
module uart_rx_sync (
  input  logic clk,
  input  logic reset,
  input  logic rx,
  output logic rx_s,
  output logic fall
);
  logic meta;
  logic rx_s_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta   <= 1'b1;
      rx_s   <= 1'b1;
      rx_s_d <= 1'b1;
    end else begin
      meta   <= rx;
      rx_s   <= meta;
      rx_s_d <= rx_s;
    end
  end

  assign fall = rx_s_d & ~rx_s;
endmodule

// File: rtl/uart_rx.sv
// Oversampling UART receiver: start-edge aligned single sample per bit centre,
// one-entry holding register with valid/ack, sticky overrun, framing-error pulse.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ  = 100000000,
  parameter int BAUD_RATE = 115200,
  parameter int DATA_BITS = UART_DATA_BITS,
  parameter int STOP_BITS = UART_STOP_BITS
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      rx,
  uart_rx_if.master bus
);
  localparam int CPB = clks_per_bit(CLK_FREQ, BAUD_RATE);
  localparam int CW  = $clog2(CPB) + 1;
  localparam int BW  = $clog2(DATA_BITS + 1);

  localparam logic [CW-1:0] HALF_M1   = CW'(CPB / 2 - 1);
  localparam logic [CW-1:0] FULL_M1   = CW'(CPB - 1);
  localparam logic [BW-1:0] LAST_DATA = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);

  uart_state_e          state;
  logic [CW-1:0]        clk_cnt;
  logic [BW-1:0]        bit_cnt;
  logic [DATA_BITS-1:0] shift_reg;
  logic [DATA_BITS-1:0] data_q;
  logic                 valid_q, ovr_q, ferr_q, stop_err;
  logic                 rx_s, fall;
  logic                 bit_tick, last_stop, done_ok, done_bad;

  uart_rx_sync u_sync (
    .clk   (clk),
    .reset (reset),
    .rx    (rx),
    .rx_s  (rx_s),
    .fall  (fall)
  );

  assign bit_tick  = (clk_cnt == FULL_M1);
  assign last_stop = (state == STOP) && bit_tick && (bit_cnt == LAST_STOP);
  assign done_ok   = last_stop && !stop_err && rx_s;
  assign done_bad  = last_stop && (stop_err || !rx_s);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      clk_cnt   <= '0;
      bit_cnt   <= '0;
      shift_reg <= '0;
      stop_err  <= 1'b0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      ovr_q     <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      ferr_q <= done_bad;

      case (state)
        // a line stuck low never produces another falling edge, so no retrigger
        IDLE: if (fall) begin
          state   <= START;
          clk_cnt <= '0;
        end
        START: if (clk_cnt == HALF_M1) begin
          clk_cnt <= '0;
          bit_cnt <= '0;
          state   <= rx_s ? IDLE : DATA;
        end else begin
          clk_cnt <= clk_cnt + CW'(1);
        end
        DATA: if (bit_tick) begin
          clk_cnt   <= '0;
          shift_reg <= {rx_s, shift_reg[DATA_BITS-1:1]};
          if (bit_cnt == LAST_DATA) begin
            bit_cnt  <= '0;
            stop_err <= 1'b0;
            state    <= STOP;
          end else begin
            bit_cnt <= bit_cnt + BW'(1);
          end
        end else begin
          clk_cnt <= clk_cnt + CW'(1);
        end
        // leaving at mid stop bit lets a back-to-back start edge be caught
        STOP: if (bit_tick) begin
          clk_cnt <= '0;
          if (!rx_s) stop_err <= 1'b1;
          if (bit_cnt == LAST_STOP) state <= IDLE;
          else                      bit_cnt <= bit_cnt + BW'(1);
        end else begin
          clk_cnt <= clk_cnt + CW'(1);
        end
        default: state <= IDLE;
      endcase

      // holding register: a completion cycle owns it, ack only acts outside it
      if (done_ok) begin
        data_q  <= shift_reg;
        valid_q <= 1'b1;
        if (valid_q && !bus.rx_ack) ovr_q <= 1'b1;
        else if (bus.rx_ack)        ovr_q <= 1'b0;
      end else if (bus.rx_ack && !last_stop) begin
        valid_q <= 1'b0;
        ovr_q   <= 1'b0;
      end
    end
  end

  assign bus.rx_data      = data_q;
  assign bus.rx_valid     = valid_q;
  assign bus.rx_overrun   = ovr_q;
  assign bus.rx_frame_err = ferr_q;
  assign bus.rx_busy      = (state != IDLE);
endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: frame-level reference model (completion
// cycle predicted from the line timing) compared every cycle, plus directed checks.
module tb_uart_rx;
  import uart_pkg::*;

  localparam int CLK_FREQ  = 1000000;
  localparam int BAUD_RATE = 100000;
  localparam int CPB       = CLK_FREQ / BAUD_RATE;
  localparam int DB        = 8;
  localparam int SB        = 1;
  localparam int NBITS     = 1 + DB + SB;
  // start edge driven just after edge P0 completes at edge P0+LAT
  localparam int LAT       = 3 + CPB / 2 + (DB + SB) * CPB;

  typedef struct {
    int          c;
    logic [DB-1:0] b;
    bit          ok;
  } frame_t;

  logic clk = 0, reset = 1, rx = 1, ack = 0;

  uart_rx_if #(.DATA_BITS(DB)) bus ();
  assign bus.rx_ack = ack;

  uart_rx #(
    .CLK_FREQ (CLK_FREQ),
    .BAUD_RATE(BAUD_RATE),
    .DATA_BITS(DB),
    .STOP_BITS(SB)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .rx   (rx),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int            n_chk = 0, n_fail = 0;
  int            cyc = 0;
  frame_t        q[$];
  frame_t        mf;
  logic          m_valid = 0, m_ovr = 0, m_err = 0;
  logic [DB-1:0] m_data = '0;
  bit            cmp_en = 0;
  int            ack_mode = 0, ack_at = -1;
  int            rise_cyc = -1, err_pulses = 0;
  bit            busy_seen = 0, prev_valid = 0;
  logic [DB-1:0] got[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // reference model: holding-register rules applied at predicted completions
  always @(posedge clk) begin
    cyc++;
    m_err = 0;
    if (!reset) begin
      m_valid = 0; m_ovr = 0; m_data = '0;
      q.delete();
    end else if (q.size() > 0 && q[0].c == cyc) begin
      mf = q.pop_front();
      if (mf.ok) begin
        if (m_valid && !ack) m_ovr = 1;
        else if (ack)        m_ovr = 0;
        m_data  = mf.b;
        m_valid = 1;
      end else begin
        m_err = 1;
      end
    end else if (ack) begin
      m_valid = 0;
      m_ovr   = 0;
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      if (!reset) begin
        chk("rst_valid",   bus.rx_valid,     0);
        chk("rst_data",    bus.rx_data,      0);
        chk("rst_overrun", bus.rx_overrun,   0);
        chk("rst_ferr",    bus.rx_frame_err, 0);
        chk("rst_busy",    bus.rx_busy,      0);
      end else begin
        chk("valid",   bus.rx_valid,     m_valid);
        chk("data",    bus.rx_data,      m_data);
        chk("overrun", bus.rx_overrun,   m_ovr);
        chk("ferr",    bus.rx_frame_err, m_err);
      end
    end
  end

  always @(negedge clk) begin
    if (reset) begin
      if (bus.rx_valid && !prev_valid) begin
        rise_cyc = cyc;
        got.push_back(bus.rx_data);
      end
      if (bus.rx_frame_err) err_pulses++;
      if (bus.rx_busy) busy_seen = 1;
    end
    prev_valid = bus.rx_valid;
  end

  // consumer: 1 = ack once per valid, 2 = random, 3 = ack at cycle ack_at
  always @(posedge clk) begin
    #1;
    case (ack_mode)
      1:       ack = bus.rx_valid && !ack;
      2:       ack = ($urandom_range(0, 3) == 0);
      3:       ack = (cyc + 1 == ack_at);
      default: ack = 0;
    endcase
  end

  task automatic wait_cyc(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic idle(input int n);
    rx = 1;
    wait_cyc(n);
  endtask

  // called just after a clock edge; drives nbits bits of the frame, LSB first
  task automatic send_frame(input logic [DB-1:0] b, input bit stop_ok,
                            input int nbits, input bit ack_here);
    logic [NBITS-1:0] bits;
    bits = {{SB{stop_ok}}, b, 1'b0};
    if (nbits == NBITS) begin
      frame_t f;
      f.c  = cyc + LAT;
      f.b  = b;
      f.ok = stop_ok;
      q.push_back(f);
      if (ack_here) ack_at = f.c;
    end
    for (int i = 0; i < nbits; i++) begin
      rx = bits[i];
      wait_cyc(CPB);
    end
  endtask

  initial begin
    #2000000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    int t0, e0;
    cmp_en = 1;
    #1 reset = 0;
    wait_cyc(4);
    chk("reset_valid", bus.rx_valid, 0);
    chk("reset_busy",  bus.rx_busy,  0);
    chk("reset_data",  bus.rx_data,  0);
    reset = 1;
    idle(5);

    // 1: single frame, latency and ack
    ack_mode = 1;
    t0 = cyc;
    send_frame(8'h55, 1, NBITS, 0);
    idle(10);
    chk("t1_latency", rise_cyc - t0, 98);
    chk("t1_data",    got[got.size()-1], 8'h55);
    chk("t1_acked",   bus.rx_valid, 0);

    // 2: back-to-back frames
    got.delete();
    send_frame(8'hA3, 1, NBITS, 0);
    send_frame(8'h3C, 1, NBITS, 0);
    idle(10);
    chk("t2_count",   got.size(), 2);
    chk("t2_first",   got[0], 8'hA3);
    chk("t2_second",  got[1], 8'h3C);
    chk("t2_overrun", bus.rx_overrun, 0);

    // 3: false start glitch then a good frame
    busy_seen = 0;
    rx = 0;
    wait_cyc(3);
    idle(15);
    chk("t3_busy_pulse", busy_seen, 1);
    chk("t3_busy_idle",  bus.rx_busy, 0);
    chk("t3_no_valid",   bus.rx_valid, 0);
    got.delete();
    send_frame(8'h7E, 1, NBITS, 0);
    idle(10);
    chk("t3_count", got.size(), 1);
    chk("t3_data",  got[0], 8'h7E);

    // 4: bad stop bit, line held low afterwards
    e0 = err_pulses;
    send_frame(8'hF0, 0, NBITS, 0);
    busy_seen = 0;
    wait_cyc(30);
    chk("t4_err_pulses", err_pulses - e0, 1);
    chk("t4_no_retrig",  busy_seen, 0);
    chk("t4_no_valid",   bus.rx_valid, 0);
    idle(3);
    got.delete();
    send_frame(8'h5A, 1, NBITS, 0);
    idle(10);
    chk("t4_recover", got[0], 8'h5A);

    // 5: overrun, then ack coinciding with completion
    ack_mode = 0;
    send_frame(8'h11, 1, NBITS, 0);
    send_frame(8'h22, 1, NBITS, 0);
    idle(10);
    chk("t5_data",    bus.rx_data,    8'h22);
    chk("t5_valid",   bus.rx_valid,   1);
    chk("t5_overrun", bus.rx_overrun, 1);
    send_frame(8'h11, 1, NBITS, 0);
    ack_mode = 3;
    send_frame(8'h22, 1, NBITS, 1);
    idle(10);
    chk("t5b_overrun", bus.rx_overrun, 0);
    chk("t5b_valid",   bus.rx_valid,   1);
    chk("t5b_data",    bus.rx_data,    8'h22);
    ack_mode = 1;
    wait_cyc(5);

    // 6: reset during the 4th data bit
    got.delete();
    send_frame(8'h99, 1, 4, 0);
    rx = 1;
    wait_cyc(5);
    reset = 0;
    wait_cyc(4);
    chk("t6_rst_busy",  bus.rx_busy,  0);
    chk("t6_rst_valid", bus.rx_valid, 0);
    reset = 1;
    idle(10);
    send_frame(8'h42, 1, NBITS, 0);
    idle(10);
    chk("t6_count", got.size(), 1);
    chk("t6_data",  got[0], 8'h42);

    // randomized frames, gaps, stop errors and acks
    ack_mode = 2;
    for (int i = 0; i < 20; i++) begin
      logic [DB-1:0] b;
      bit ok;
      b  = DB'($urandom);
      ok = ($urandom_range(0, 5) != 0);
      send_frame(b, ok, NBITS, 0);
      if (!ok)                              idle(2 + int'($urandom_range(0, 2)));
      else if ($urandom_range(0, 1) == 1)   idle(int'($urandom_range(1, 3)));
    end
    idle(LAT);
    ack_mode = 1;
    idle(20);
    chk("final_valid", bus.rx_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
Asynchronous serial receiver, 8N1 by default; it is the receive-side counterpart of the team's UART transmitter. It oversamples the rx line with the system clock and locates each bit centre from the start-bit edge. Each completed byte lands in a one-entry holding register with a valid/ack handshake toward the core, for example an MMIO UART data register.

Parameters:
- CLK_FREQ, 100000000, system clock frequency in Hz.
- BAUD_RATE, 115200, line rate in bits/s. CLKS_PER_BIT = CLK_FREQ / BAUD_RATE, integer division, must be >= 4.
- DATA_BITS, 8, data bits per frame, sent LSB first.
- STOP_BITS, 1, stop bits per frame, 1 or 2.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- rx  in  1  serial line, asynchronous to clk, idle high.
- rx_data  out  DATA_BITS  last received byte; stable while rx_valid=1 unless overwritten by an overrun.
- rx_valid  out  1  holding register full; level signal, held until acked.
- rx_ack  in  1  consumer pulse; clears rx_valid.
- rx_overrun  out  1  sticky; a byte completed while rx_valid=1 and no ack arrived that cycle.
- rx_frame_err  out  1  one-cycle pulse; a stop bit was sampled as 0.
- rx_busy  out  1  high in every state except IDLE.

Behaviour:
- Reset state: rx_data=0, rx_valid=0, rx_overrun=0, rx_frame_err=0, rx_busy=0, FSM=IDLE, both synchroniser flops=1, counters=0. Reset mid-frame abandons the frame with no outputs asserted.
- Synchroniser: 2-flop sync on rx giving rx_s. A third flop holds rx_s_d for falling-edge detection. Pin-to-rx_s latency is 2 cycles.
- Counters: clk_cnt width is clog2(CLKS_PER_BIT)+1. bit_cnt width is clog2(DATA_BITS+1). shift_reg is DATA_BITS wide.
- IDLE: on rx_s_d=1 and rx_s=0, go to START with clk_cnt=0. A line held low continuously never retriggers the FSM.
- START: when clk_cnt reaches CLKS_PER_BIT/2 - 1, sample rx_s.
  - rx_s=1: false start, return to IDLE, no outputs.
  - rx_s=0: go to DATA with clk_cnt=0 and bit_cnt=0.
- DATA: sample when clk_cnt reaches CLKS_PER_BIT-1, then reset clk_cnt.
  - shift_reg <= {rx_s, shift_reg[DATA_BITS-1:1]}, which gives LSB-first ordering.
  - After DATA_BITS samples, go to STOP.
- STOP: sample each stop bit at the same mid-bit spacing. Any stop sample of 0 sets the error flag for this frame. After STOP_BITS samples, go to IDLE; the same cycle is the completion cycle C.
- Completion cycle C with no error:
  - rx_data <= shift_reg and rx_valid <= 1.
  - If rx_valid was already 1 and rx_ack=0 in C, rx_overrun <= 1 and the old byte is lost.
- Completion cycle C with error: rx_frame_err=1 for exactly one cycle, the byte is discarded, and rx_data, rx_valid and rx_overrun are unchanged.
- rx_ack outside C: rx_valid <= 0 and rx_overrun <= 0. rx_ack while rx_valid=0 has no effect.
- rx_ack and a good completion in the same cycle: the new byte loads, rx_valid stays 1, no overrun.
- Latency from the rx pin falling edge to rx_valid rising: 2 + CLKS_PER_BIT/2 + (DATA_BITS+STOP_BITS)*CLKS_PER_BIT + 1 cycles, with +/-1 cycle for synchroniser phase.
- Back-to-back frames: IDLE is re-entered mid-stop-bit, so the next start edge is caught with no gap required.
- Noise: no majority voting; a single sample per bit is the design point.

Decomposition:
- Shared package uart_pkg:
  - state enum IDLE/START/DATA/STOP (2-bit encoding);
  - function clks_per_bit(clk_freq, baud);
  - default DATA_BITS/STOP_BITS constants, also used by the transmitter.
- One sub-module, uart_rx_sync: 2-flop synchroniser plus falling-edge detect, with reset value 1 (idle line). The FSM, counters and holding register stay in uart_rx.

Test Plan:
All tests use CLK_FREQ=1000000 and BAUD_RATE=100000, so CLKS_PER_BIT=10.
1. Drive frame 0x55 (8N1), then pulse rx_ack on rx_valid -> rx_data=0x55 and rx_valid rises 2+5+90+1=98 cycles (+/-1) after the start edge; rx_frame_err=0; rx_valid falls the cycle after the ack.
2. Drive 0xA3 then 0x3C back-to-back with no idle gap, acking each -> two rx_valid events with 0xA3 then 0x3C; rx_overrun stays 0.
3. Pulse rx low for 3 cycles -> rx_busy pulses, FSM returns to IDLE, rx_valid stays 0; a following frame 0x7E is received correctly.
4. Frame 0xF0 with stop bit=0, with rx_valid=0 beforehand -> rx_frame_err high for exactly 1 cycle; rx_valid stays 0; the line held low afterwards does not start a new frame until a high-then-low edge.
5. Send 0x11 then 0x22 with no ack -> rx_data=0x22, rx_valid=1, rx_overrun=1. Repeat with rx_ack coinciding with the 0x22 completion cycle -> rx_overrun=0, rx_valid=1.
6. Assert reset (0) during the 4th data bit of 0x99, release, then send 0x42 -> all outputs 0 during reset, no rx_valid for the aborted frame, 0x42 received correctly.
